// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared encodings for the sequential 32x32 multiplier.
// Op codes, FSM states, partial-product indices and their shifts.
package mul_seq_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULXSS = 2'd1;
    localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULXUU = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_RESP
    } state_e;

    // Issue order: bit 1 selects a[31:16], bit 0 selects b[31:16].
    localparam logic [1:0] PART_LL = 2'd0;
    localparam logic [1:0] PART_LH = 2'd1;
    localparam logic [1:0] PART_HL = 2'd2;
    localparam logic [1:0] PART_HH = 2'd3;

    localparam logic [5:0] SHIFT_LL = 6'd0;
    localparam logic [5:0] SHIFT_LH = 6'd16;
    localparam logic [5:0] SHIFT_HL = 6'd16;
    localparam logic [5:0] SHIFT_HH = 6'd32;

    function automatic logic [5:0] part_shift(input logic [1:0] idx);
        logic [5:0] sh;
        case (idx)
            PART_LL: sh = SHIFT_LL;
            PART_LH: sh = SHIFT_LH;
            PART_HL: sh = SHIFT_HL;
            default: sh = SHIFT_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul_seq_cell16.sv
// mul_seq_cell16: registered 16x16 unsigned multiplier, CELL_LAT stages.
// Ports: clk, reset_n (async clear), en (advance), a, b -> p (32-bit).
module mul_seq_cell16 #(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] pipe_q [CELL_LAT];
    logic [31:0] pipe_d [CELL_LAT];

    always_comb begin
        pipe_d = pipe_q;
        if (en) begin
            pipe_d[0] = {16'b0, a} * {16'b0, b};
            for (int i = 1; i < CELL_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELL_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign p = pipe_q[CELL_LAT-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 MUL/MULX* over four time-shared 16x16 partials.
// Ports: clk, reset_n, in_valid/in_ready/in_op/in_src_a/in_src_b,
//        out_valid/out_ready/out_result, busy.
// Define MUL_SEQ_LOW_FASTPATH_EN to skip the HH partial for MUL.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src_a,
    input  logic [31:0] in_src_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [2:0]  issue_q, issue_d;
    logic [2:0]  done_q, done_d;
    logic [31:0] res_q, res_d;

    // {valid, index} travels beside the cell so each product is shifted right.
    logic [CELL_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [1:0]          tag_idx_q [CELL_LAT];
    logic [1:0]          tag_idx_d [CELL_LAT];

    logic        issue;
    logic [1:0]  issue_idx;
    logic [2:0]  n_parts;
    logic [15:0] cell_a, cell_b;
    logic [31:0] cell_p;
    logic        cell_en;
    logic        ret_vld;
    logic [1:0]  ret_idx;
    logic [63:0] fixed;

    always_comb begin
`ifdef MUL_SEQ_LOW_FASTPATH_EN
        n_parts = (op_q == MUL_OP_MUL) ? 3'd3 : 3'd4;
`else
        n_parts = 3'd4;
`endif
    end

    assign issue     = (state_q == ST_RUN) && (issue_q < n_parts);
    assign issue_idx = issue_q[1:0];
    assign cell_a    = issue_idx[1] ? a_q[31:16] : a_q[15:0];
    assign cell_b    = issue_idx[0] ? b_q[31:16] : b_q[15:0];
    assign cell_en   = issue || (|tag_vld_q);
    assign ret_vld   = tag_vld_q[CELL_LAT-1];
    assign ret_idx   = tag_idx_q[CELL_LAT-1];

    mul_seq_cell16 #(
        .CELL_LAT(CELL_LAT)
    ) u_cell (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (cell_en),
        .a      (cell_a),
        .b      (cell_b),
        .p      (cell_p)
    );

    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_idx_d = tag_idx_q;
        if (cell_en) begin
            tag_vld_d[0] = issue;
            tag_idx_d[0] = issue_idx;
            for (int i = 1; i < CELL_LAT; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_idx_d[i] = tag_idx_q[i-1];
            end
        end
    end

    // Signed correction of the unsigned 64-bit product.
    always_comb begin
        fixed = acc_q;
        if (op_q == MUL_OP_MULXSS) begin
            if (a_q[31]) fixed = fixed - {b_q, 32'b0};
            if (b_q[31]) fixed = fixed - {a_q, 32'b0};
        end else if (op_q == MUL_OP_MULXSU && a_q[31]) begin
            fixed = fixed - {b_q, 32'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        issue_d = issue_q;
        done_d  = done_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_src_a;
                    b_d     = in_src_b;
                    acc_d   = '0;
                    issue_d = '0;
                    done_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) issue_d = issue_q + 3'd1;
                if (ret_vld) begin
                    acc_d  = acc_q
                           + ({32'b0, cell_p} << part_shift(ret_idx));
                    done_d = done_q + 3'd1;
                end
                if (done_q == n_parts) state_d = ST_FIX;
            end
            ST_FIX: begin
                acc_d   = fixed;
                res_d   = (op_q == MUL_OP_MUL) ? fixed[31:0]
                                               : fixed[63:32];
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            issue_q   <= '0;
            done_q    <= '0;
            res_q     <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < CELL_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            issue_q   <= issue_d;
            done_q    <= done_d;
            res_q     <= res_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_RESP);
    assign out_result = res_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed + random checks of mul_seq_ctrl against
// an arithmetic reference of the 32x32 product variants.
module tb_mul_seq_ctrl;

    localparam int CELL_LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [31:0] in_src_a = '0;
    logic [31:0] in_src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq_ctrl #(
        .CELL_LAT(CELL_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src_a  (in_src_a),
        .in_src_b  (in_src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0:    p = ua * ub;
            2'd1:    p = longint'(sa * sb);
            2'd2:    p = longint'(sa * longint'(ub));
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        int n;
        n = 4;
`ifdef MUL_SEQ_LOW_FASTPATH_EN
        if (op == 2'd0) n = 3;
`else
        if (op == 2'd0) n = 4;
`endif
        return n + CELL_LAT + 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         input string tag);
        logic [31:0] exp;
        int k;
        exp = ref_mul(op, a, b);
        out_ready = (hold == 0);
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        check({tag, " rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src_a = a;
        in_src_b = b;
        tick();
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_src_a = $urandom;
        in_src_b = $urandom;
        check({tag, " busy"}, 64'(busy), 64'd1);
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, " lat"}, 64'(k), 64'(exp_lat(op)));
        check({tag, " res"}, 64'(out_result), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold"},
                  {out_valid, in_ready, out_result},
                  {1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        tick();
        check({tag, " done"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #2;
        check("rst", {in_ready, busy, out_valid, out_result},
              {1'b1, 1'b0, 1'b0, 32'h0});
        #10 reset_n = 1'b1;
        tick();

        do_op(2'd0, 32'h0001_0003, 32'h0002_0005, 0, "mul_small");
        check("mul_small_val", 64'(ref_mul(2'd0, 32'h0001_0003,
              32'h0002_0005)), 64'h000B_000F);
        do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulxuu_ff");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulxss_ff");
        do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulxss_80");
        do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulxsu_ff");
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ff");
        do_op(2'd2, 32'h7FFF_FFFF, 32'h8000_0000, 1, "mulxsu_mix");
        do_op(2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2, "mulxss_mix");

        // Backpressure with an ignored request while the result waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'd0;
        in_src_a  = 32'h0000_1234;
        in_src_b  = 32'h0000_5678;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_op    = 2'd3;
            in_src_a = $urandom;
            tick();
            check("bp_hold", {out_valid, in_ready, busy, out_result},
                  {1'b1, 1'b0, 1'b1, 32'h0626_0060});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {out_valid, in_ready, busy}, 3'b010);
        tick();
        check("bp_no_ghost", {out_valid, in_ready, busy}, 3'b010);

        // Reset during the second RUN cycle.
        in_valid = 1'b1;
        in_op    = 2'd3;
        in_src_a = 32'hFFFF_FFFF;
        in_src_b = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid", {out_valid, busy, in_ready, out_result},
              {1'b0, 1'b0, 1'b1, 32'h0});
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        do_op(2'd3, 32'h0000_0002, 32'h8000_0000, 0, "post_rst");

        for (int t = 0; t < 40; t++) begin
            do_op(2'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
